// File: rtl/hps_sw_edge_ctrl.sv
// Debounced 4-bit switch port with edge capture and masked IRQ (Avalon-MM).
// Define HPS_SW_DEBOUNCE_EN for per-bit debounce FSMs and the PERIOD register.
module hps_sw_edge_ctrl #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd5000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    logic [3:0]  meta_q, sync_q;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  edge_q, edge_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  deb, deb_nx;
    logic [15:0] period_rd;
    logic [3:0]  clr;
    logic        unused_wd;

    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 4'b0000;
            sync_q <= 4'b0000;
        end else begin
            meta_q <= in_port;
            sync_q <= meta_q;
        end
    end

`ifdef HPS_SW_DEBOUNCE_EN
    typedef enum logic {ST_STABLE, ST_COUNTING} st_e;

    st_e         state_q [4];
    st_e         state_d [4];
    logic [15:0] cnt_q   [4];
    logic [15:0] cnt_d   [4];
    logic [3:0]  deb_q, deb_d;
    logic [15:0] period_q, period_d;
    logic [15:0] plim;

    // A zero period is treated as one, so the terminal count is 0 either way.
    assign plim = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;

    always_comb begin
        period_d = period_q;
        deb_d    = deb_q;
        if (write && address == 2'd2)
            period_d = writedata[15:0];
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_STABLE: begin
                    if (sync_q[i] != deb_q[i]) begin
                        state_d[i] = ST_COUNTING;
                        cnt_d[i]   = 16'd0;
                    end
                end
                ST_COUNTING: begin
                    if (sync_q[i] == deb_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = 16'd0;
                    end else if (cnt_q[i] >= plim) begin
                        deb_d[i]   = sync_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = 16'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_q    <= 4'b0000;
            period_q <= DEFAULT_PERIOD;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= 16'd0;
            end
        end else begin
            deb_q    <= deb_d;
            period_q <= period_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign deb       = deb_q;
    assign deb_nx    = deb_d;
    assign period_rd = period_q;
`else
    logic [15:0] unused_dp;

    assign unused_dp = DEFAULT_PERIOD;
    assign deb       = sync_q;
    assign deb_nx    = meta_q;
    assign period_rd = 16'd0;
`endif

    // Set takes priority over write-1-to-clear on the same bit.
    always_comb begin
        clr     = (write && address == 2'd3) ? writedata[3:0] : 4'b0000;
        mask_d  = (write && address == 2'd1) ? writedata[3:0] : mask_q;
        edge_d  = (edge_q & ~clr) | (deb_nx ^ deb);
        rdata_d = 32'd0;
        unique case (address)
            2'd0: rdata_d = {28'd0, deb};
            2'd1: rdata_d = {28'd0, mask_q};
            2'd2: rdata_d = {16'd0, period_rd};
            2'd3: rdata_d = {28'd0, edge_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q  <= 4'b0000;
            edge_q  <= 4'b0000;
            rdata_q <= 32'd0;
        end else begin
            mask_q  <= mask_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(edge_q & mask_q);

endmodule
